// File: rtl/bnn_classifier_seq.sv
// Sequential binary neural network classifier with runtime-loadable weights.
// Evaluates one hidden neuron or one output score per enabled cycle, then reports argmax class and margin.
module bnn_classifier_seq #(
    parameter int N_IN   = 8,
    parameter int N_HID  = 8,
    parameter int N_OUT  = 2,
    parameter int BIAS_W = 4,
    localparam int CLS_W = (N_OUT > 2) ? $clog2(N_OUT) : 1,
    localparam int MRG_W = $clog2(N_HID + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              start,
    input  logic [N_IN-1:0]   feat,
    output logic              busy,
    output logic              done,
    output logic [CLS_W-1:0]  cls,
    output logic [MRG_W-1:0]  margin,
    output logic [N_HID-1:0]  hid_act,
    input  logic              wl_valid,
    input  logic [1:0]        wl_sel,
    input  logic [3:0]        wl_idx,
    input  logic [15:0]       wl_data,
    output logic              wl_ready
);

    localparam int PC_W   = $clog2(N_IN + 1);
    localparam int ACC_W  = PC_W + BIAS_W + 1;
    localparam int HID_IW = $clog2(N_HID);
    localparam logic [HID_IW-1:0] HID_LAST = HID_IW'(N_HID - 1);
    localparam logic [CLS_W-1:0]  OUT_LAST = CLS_W'(N_OUT - 1);
    localparam logic [4:0]        HID_ROWS = 5'(N_HID);
    localparam logic [4:0]        OUT_ROWS = 5'(N_OUT);

    typedef enum logic [1:0] {S_IDLE, S_HID, S_OUT, S_DONE} state_t;

    state_t state, state_nxt;

    logic [N_IN-1:0]   w_ih [N_HID];
    logic [BIAS_W-1:0] b_h  [N_HID];
    logic [N_HID-1:0]  w_ho [N_OUT];

    logic [N_IN-1:0]   x;
    logic [N_HID-1:0]  hid;
    logic [HID_IW-1:0] hid_idx;
    logic [CLS_W-1:0]  out_idx;
    logic [MRG_W-1:0]  best_score, second_score;
    logic [CLS_W-1:0]  best_idx;

    logic [N_IN-1:0]         xn_in;
    logic [PC_W-1:0]         pc_in;
    logic signed [ACC_W-1:0] acc;
    logic                    act;
    logic [N_HID-1:0]        xn_hid;
    logic [MRG_W-1:0]        score;
    logic [MRG_W-1:0]        best_nxt, second_nxt;
    logic [CLS_W-1:0]        idx_nxt;
    logic                    wr_en;
    logic                    wl_data_unused;

    assign wl_data_unused = ^wl_data;
    assign wr_en = wl_valid & wl_ready;

    // Hidden neuron: XNOR popcount plus sign-extended bias, activation is the sign test.
    always_comb begin
        xn_in = ~(x ^ w_ih[hid_idx]);
        pc_in = '0;
        for (int b = 0; b < N_IN; b++)
            pc_in = pc_in + PC_W'(xn_in[b]);
        acc = $signed({{(ACC_W - PC_W){1'b0}}, pc_in})
            + $signed({{(ACC_W - BIAS_W){b_h[hid_idx][BIAS_W-1]}}, b_h[hid_idx]});
        act = ~acc[ACC_W-1];
    end

    // Output score and running best/second-best; strict compare keeps the lowest index on ties.
    always_comb begin
        xn_hid = ~(hid ^ w_ho[out_idx]);
        score  = '0;
        for (int b = 0; b < N_HID; b++)
            score = score + MRG_W'(xn_hid[b]);
        best_nxt   = best_score;
        second_nxt = second_score;
        idx_nxt    = best_idx;
        if (score > best_score) begin
            second_nxt = best_score;
            best_nxt   = score;
            idx_nxt    = out_idx;
        end else if (score > second_score) begin
            second_nxt = score;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        wl_ready  = (state == S_IDLE);
        if (ena) begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_HID;
                S_HID:   if (hid_idx == HID_LAST) state_nxt = S_OUT;
                S_OUT:   if (out_idx == OUT_LAST) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_HID; i++) begin
                w_ih[i] <= '0;
                b_h[i]  <= '0;
            end
            for (int k = 0; k < N_OUT; k++)
                w_ho[k] <= '0;
            x            <= '0;
            hid          <= '0;
            hid_idx      <= '0;
            out_idx      <= '0;
            best_score   <= '0;
            second_score <= '0;
            best_idx     <= '0;
            cls          <= '0;
            margin       <= '0;
            hid_act      <= '0;
        end else begin
            if (wr_en) begin
                case (wl_sel)
                    2'd0: if ({1'b0, wl_idx} < HID_ROWS) w_ih[wl_idx[HID_IW-1:0]] <= wl_data[N_IN-1:0];
                    2'd1: if ({1'b0, wl_idx} < HID_ROWS) b_h[wl_idx[HID_IW-1:0]]  <= wl_data[BIAS_W-1:0];
                    2'd2: if ({1'b0, wl_idx} < OUT_ROWS) w_ho[wl_idx[CLS_W-1:0]]  <= wl_data[N_HID-1:0];
                    default: ;
                endcase
            end
            if (ena) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            x            <= feat;
                            hid_idx      <= '0;
                            out_idx      <= '0;
                            best_score   <= '0;
                            second_score <= '0;
                            best_idx     <= '0;
                        end
                    end
                    S_HID: begin
                        hid[hid_idx] <= act;
                        hid_idx      <= hid_idx + HID_IW'(1);
                    end
                    S_OUT: begin
                        best_score   <= best_nxt;
                        second_score <= second_nxt;
                        best_idx     <= idx_nxt;
                        out_idx      <= out_idx + CLS_W'(1);
                        // Results are captured on entry to DONE so they are valid while done is high.
                        if (out_idx == OUT_LAST) begin
                            cls     <= idx_nxt;
                            margin  <= best_nxt - second_nxt;
                            hid_act <= hid;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
